intersection_lamp_driver: RTL
=============================

Name: intersection_lamp_driver

Overview:
- Consumes the 16-bit control word driven by the HPS-writable GPIO output register (`soc_system` PIO `out_port`).
- Turns it into safe, timed lamp drives for a 4-approach intersection.
- Enforces amber timing, conflicting-green interlock, all-red clearance and a software heartbeat watchdog, independent of QNX software timing.
- On any fault, forces flashing red until software explicitly clears it.

Parameters:
- AMBER_CYCLES, 150000000 — amber duration in clk cycles (3 s at 50 MHz); must be ≥1.
- FLASH_HALF, 25000000 — half-period of flash generator in clk cycles; must be ≥1.
- WDT_CYCLES, 50000000 — max clk cycles between heartbeat toggles; must be ≥2.
- CNT_W, 32 — width of all internal counters; must hold each parameter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ctrl_word  in  16  control word from PIO out_port, same clock domain
- lamp_red  out  4  red lamp per approach [N,E,S,W] = bits [0,1,2,3]
- lamp_amber  out  4  amber lamp per approach
- lamp_green  out  4  green lamp per approach
- walk  out  2  [0] = walk across E/W roads, [1] = walk across N/S roads
- fault  out  1  latched fault indicator
- fault_code  out  2  00 none, 01 conflict, 10 watchdog

Behaviour:
- Reset and clocking:
  - Reset reset_n, asynchronous, active-low; clock clk.
  - On reset: all approach FSMs RED, lamp_red=4'hF, lamp_amber=0, lamp_green=0, walk=0, fault=0, fault_code=0, all counters 0, heartbeat history 0, flash_phase=0.
  - Reset asserted mid-operation (including mid-amber) forces these values immediately.
- Control word map:
  - Approach i command = ctrl_word[2i+1:2i]: 00 RED, 01 GREEN, 10 AMBER (treated as "stop"), 11 FLASH.
  - Bit 8 = walk request E/W; bit 9 = walk request N/S.
  - Bit 14 = enable; bit 15 = heartbeat.
  - Bits 13:10 ignored.
- Pipeline:
  - ctrl_word registered into ctrl_q each cycle.
  - FSMs update from ctrl_q on the next edge.
  - Lamp outputs are a decode of registered FSM state.
  - Permitted transitions appear on the lamps 2 clock edges after ctrl_word changes.
- Conflict groups: NS = {0,2}, EW = {1,3}.
- Per-approach FSM (enable=1, fault=0):
  - RED: cmd GREEN and both opposing-group FSMs in RED → GREEN. cmd FLASH → FLASH. Otherwise stay RED (cmd AMBER from RED stays RED).
  - GREEN: cmd GREEN → stay. Any other cmd → AMBER, load amber counter with AMBER_CYCLES-1.
  - AMBER: decrement each cycle; at 0 → RED regardless of cmd. Amber is never shortened or extended. A re-request of GREEN during amber is honoured only via the RED rule afterwards.
  - FLASH: cmd FLASH → stay. Any other cmd → RED.
- Lamp decode:
  - RED/GREEN/AMBER states drive exactly one lamp.
  - FLASH drives amber=flash_phase, red=0, green=0.
  - Amber visible for exactly AMBER_CYCLES cycles.
- Walk:
  - walk[0] = ctrl_q[8] & E and W FSMs both RED.
  - walk[1] = ctrl_q[9] & N and S FSMs both RED.
  - 0 when disabled or faulted.
- Flash generator:
  - Free-running counter; flash_phase toggles every FLASH_HALF cycles.
  - Runs in all modes.
- Enable=0 (no fault): all FSMs forced RED immediately, amber counters cleared, watchdog counter held at 0, walk=0.
- Watchdog (enable=1):
  - Counter increments each cycle.
  - Cleared when ctrl_q[15] differs from its previous registered value.
  - Reaching WDT_CYCLES-1 sets fault with code 10.
- Conflict: ctrl_q requests GREEN on any NS and any EW approach in the same cycle (enable=1) → fault, code 01.
- Fault:
  - Latched; fault_code holds the first cause. Conflict has priority if both causes occur in the same cycle.
  - While faulted: lamp_red=4{flash_phase}, amber=green=walk=0, FSMs held RED.
  - Cleared only by ctrl_q[14]=0: that cycle fault→0, fault_code→00, FSMs RED.

Test Plan (AMBER_CYCLES=4, FLASH_HALF=3, WDT_CYCLES=20):
1. Reset, then ctrl_word=0x4001 with heartbeat toggled every 5 cycles → lamp_green=4'b0001 exactly 2 edges after write; red=4'b1110.
2. From case 1, write 0x4000 (N to RED) → N amber for exactly 4 cycles, then red. A GREEN re-request written mid-amber does not shorten amber.
3. N green, write 0x4006 (N stop, E green) → E stays red through N's 4 amber cycles, goes green 1 cycle after N reaches RED; no cycle with greens in both groups.
4. Write 0x4005 (N and E green) → fault=1, fault_code=01, lamp_red toggles every 3 cycles, green=0. Write 0x0000 → fault clears, all red. Write 0x4001 → N green again.
5. Enable with heartbeat frozen → fault_code=10 after 20 cycles; then toggling heartbeat alone does not clear it; only enable=0 clears it.
6. Cases 2 and 5 variants: assert reset_n=0 mid-amber → immediate all-red, fault=0. Separately, ctrl_word=0x4300 with all approaches red → walk=2'b11; write 0x4301 → walk[0]=1 stays, walk[1] drops when N goes green.

Source files
------------

// File: rtl/intersection_lamp_driver.sv
// Timed, interlocked lamp drive for a 4-approach intersection, fed by the
// HPS PIO control word; latches conflict/watchdog faults into flashing red.
`timescale 1ns/1ps
module intersection_lamp_driver #(
  parameter int unsigned AMBER_CYCLES = 150000000,
  parameter int unsigned FLASH_HALF   = 25000000,
  parameter int unsigned WDT_CYCLES   = 50000000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ctrl_word,
  output logic [3:0]  lamp_red,
  output logic [3:0]  lamp_amber,
  output logic [3:0]  lamp_green,
  output logic [1:0]  walk,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [1:0] ST_RED   = 2'd0;
  localparam logic [1:0] ST_GREEN = 2'd1;
  localparam logic [1:0] ST_AMBER = 2'd2;
  localparam logic [1:0] ST_FLASH = 2'd3;
  localparam logic [1:0] CMD_GREEN = 2'b01;
  localparam logic [1:0] CMD_FLASH = 2'b11;
  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_CONFLICT = 2'b01;
  localparam logic [1:0] CODE_WDT      = 2'b10;
  localparam logic [CNT_W-1:0] AMBER_LOAD = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] WDT_LAST   = CNT_W'(WDT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  logic [15:0]           ctrl_q_r;
  logic                  hb_prev_r;
  logic [3:0][1:0]       state_r;
  logic [3:0][1:0]       state_next_s;
  logic [3:0][CNT_W-1:0] amber_cnt_r;
  logic [3:0][CNT_W-1:0] amber_next_s;
  logic [CNT_W-1:0]      wdt_cnt_r;
  logic [CNT_W-1:0]      flash_cnt_r;
  logic                  flash_phase_r;
  logic                  fault_r;
  logic [1:0]            fault_code_r;
  logic [3:0][1:0]       cmd_s;
  logic                  enable_s;
  logic                  hb_toggle_s;
  logic                  ns_green_req_s;
  logic                  ew_green_req_s;
  logic                  ns_red_s;
  logic                  ew_red_s;
  logic                  conflict_s;
  logic                  wdt_expire_s;
  logic                  hold_red_s;
  logic                  unused_bits_s;

  assign cmd_s          = ctrl_q_r[7:0];
  assign enable_s       = ctrl_q_r[14];
  assign hb_toggle_s    = ctrl_q_r[15] ^ hb_prev_r;
  assign unused_bits_s  = ^ctrl_q_r[13:10];
  assign ns_green_req_s = (cmd_s[0] == CMD_GREEN) | (cmd_s[2] == CMD_GREEN);
  assign ew_green_req_s = (cmd_s[1] == CMD_GREEN) | (cmd_s[3] == CMD_GREEN);
  assign ns_red_s       = (state_r[0] == ST_RED) & (state_r[2] == ST_RED);
  assign ew_red_s       = (state_r[1] == ST_RED) & (state_r[3] == ST_RED);
  assign conflict_s     = enable_s & ~fault_r & ns_green_req_s & ew_green_req_s;
  assign wdt_expire_s   = enable_s & ~fault_r & (wdt_cnt_r == WDT_LAST);
  // A fault being raised this cycle already pins every approach to red.
  assign hold_red_s     = ~enable_s | fault_r | conflict_s | wdt_expire_s;

  assign fault      = fault_r;
  assign fault_code = fault_code_r;

  // Control word input register and heartbeat history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q_r  <= 16'h0000;
      hb_prev_r <= 1'b0;
    end else begin
      ctrl_q_r  <= ctrl_word;
      hb_prev_r <= ctrl_q_r[15];
    end
  end

  // Approach FSM state and amber counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= {4{ST_RED}};
      amber_cnt_r <= {4{CNT_ZERO}};
    end else begin
      state_r     <= state_next_s;
      amber_cnt_r <= amber_next_s;
    end
  end

  // Approach FSM next-state logic with cross-group green interlock
  always_comb begin
    state_next_s = state_r;
    amber_next_s = amber_cnt_r;
    for (int i = 0; i < 4; i++) begin
      if (hold_red_s) begin
        state_next_s[i] = ST_RED;
        amber_next_s[i] = CNT_ZERO;
      end else begin
        case (state_r[i])
          ST_RED: begin
            if ((cmd_s[i] == CMD_GREEN) && (i[0] ? ns_red_s : ew_red_s)) begin
              state_next_s[i] = ST_GREEN;
            end else if (cmd_s[i] == CMD_FLASH) begin
              state_next_s[i] = ST_FLASH;
            end else begin
              state_next_s[i] = ST_RED;
            end
          end
          ST_GREEN: begin
            if (cmd_s[i] == CMD_GREEN) begin
              state_next_s[i] = ST_GREEN;
            end else begin
              state_next_s[i] = ST_AMBER;
              amber_next_s[i] = AMBER_LOAD;
            end
          end
          ST_AMBER: begin
            // Amber runs to completion whatever is commanded meanwhile.
            if (amber_cnt_r[i] == CNT_ZERO) begin
              state_next_s[i] = ST_RED;
            end else begin
              state_next_s[i] = ST_AMBER;
              amber_next_s[i] = amber_cnt_r[i] - CNT_ONE;
            end
          end
          ST_FLASH: begin
            if (cmd_s[i] == CMD_FLASH) begin
              state_next_s[i] = ST_FLASH;
            end else begin
              state_next_s[i] = ST_RED;
            end
          end
          default: begin
            state_next_s[i] = ST_RED;
            amber_next_s[i] = CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Lamp and walk decode from registered state
  always_comb begin
    lamp_red   = 4'h0;
    lamp_amber = 4'h0;
    lamp_green = 4'h0;
    walk       = 2'b00;
    if (fault_r) begin
      lamp_red = {4{flash_phase_r}};
    end else if (!enable_s) begin
      lamp_red = 4'hF;
    end else begin
      walk = {ctrl_q_r[9] & ns_red_s, ctrl_q_r[8] & ew_red_s};
      for (int i = 0; i < 4; i++) begin
        case (state_r[i])
          ST_RED:   lamp_red[i]   = 1'b1;
          ST_GREEN: lamp_green[i] = 1'b1;
          ST_AMBER: lamp_amber[i] = 1'b1;
          ST_FLASH: lamp_amber[i] = flash_phase_r;
          default:  lamp_red[i]   = 1'b1;
        endcase
      end
    end
  end

  // Free-running flash generator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt_r   <= CNT_ZERO;
      flash_phase_r <= 1'b0;
    end else if (flash_cnt_r == FLASH_LAST) begin
      flash_cnt_r   <= CNT_ZERO;
      flash_phase_r <= ~flash_phase_r;
    end else begin
      flash_cnt_r   <= flash_cnt_r + CNT_ONE;
    end
  end

  // Heartbeat watchdog counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_cnt_r <= CNT_ZERO;
    end else if (!enable_s || fault_r || hb_toggle_s) begin
      wdt_cnt_r <= CNT_ZERO;
    end else if (wdt_cnt_r != WDT_LAST) begin
      wdt_cnt_r <= wdt_cnt_r + CNT_ONE;
    end else begin
      wdt_cnt_r <= wdt_cnt_r;
    end
  end

  // Fault latch; first cause wins, conflict outranks watchdog
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_r      <= 1'b0;
      fault_code_r <= CODE_NONE;
    end else if (!enable_s) begin
      fault_r      <= 1'b0;
      fault_code_r <= CODE_NONE;
    end else if (conflict_s) begin
      fault_r      <= 1'b1;
      fault_code_r <= CODE_CONFLICT;
    end else if (wdt_expire_s) begin
      fault_r      <= 1'b1;
      fault_code_r <= CODE_WDT;
    end else begin
      fault_r      <= fault_r;
      fault_code_r <= fault_code_r;
    end
  end

endmodule
